// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    // Controller states of the divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 4;

    // Ceiling log2. Returns the number of bits needed to encode value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the step counter, which must be able to hold the value WIDTH.
    function automatic int div_cnt_width(input int width);
        return (clog2(width + 1) < 1) ? 1 : clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {A,Q} left, trial-subtract M,
// keep the difference when it is non-negative and record the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   a_shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             unused_trial_bit;

    // The shifted remainder needs WIDTH+1 bits because it can reach 2*M-1.
    // A borrow out of the top bit means the trial subtraction went negative.
    // A restored or kept remainder is always below M, so WIDTH bits hold it.
    always_comb begin
        a_shifted        = {a_in, q_in[WIDTH-1]};
        trial            = {1'b0, a_shifted} - {2'b00, m_in};
        borrow           = trial[WIDTH+1];
        unused_trial_bit = trial[WIDTH];
        if (borrow) begin
            a_out = a_shifted[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end else begin
            a_out = trial[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Divide-by-zero finishes in a single cycle
// with quotient all ones and remainder equal to the dividend.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands,
// truncating division; magnitudes at load, sign fix-up on entry to DONE).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] final_q;
    logic [WIDTH-1:0] final_r;

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a_in (a_q),
        .q_in (q_q),
        .m_in (m_q),
        .a_out(step_a),
        .q_out(step_q)
    );

    // Operand magnitudes fed to the unsigned core, and the sign-corrected
    // result presented on the final step. Most-negative / -1 wraps naturally.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
        final_q      = q_neg_q ? -step_q : step_q;
        final_r      = r_neg_q ? -step_a : step_a;
`else
        dividend_mag = dividend;
        divisor_mag  = divisor;
        final_q      = step_q;
        final_r      = step_a;
`endif
    end

    // Next-state and datapath control; results only change on entry to DONE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        a_d     = '0;
                        q_d     = dividend_mag;
                        m_d     = divisor_mag;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = RUN;
`ifdef DIV_SIGNED_EN
                        q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_d = dividend[WIDTH-1];
`endif
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = final_q;
                    remainder_d = final_r;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse and also
// watches busy, output stability and reset behaviour.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tb_end   = 1'b0;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model used for the exhaustive sweep.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        e.a   = a;
        e.b   = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa  = $signed(a);
            sb  = $signed(b);
`else
            sa  = int'(a);
            sb  = int'(b);
`endif
            e.q   = W'(sa / sb);
            e.r   = W'(sa % sb);
            e.dbz = 1'b0;
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Issue one operation; start is held for 'hold' edges, with junk operands
    // after the first edge to show they are ignored while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int hold);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.lat = (b == '0) ? 1 : W + 1;
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            dividend = ~a;
            divisor  = b + W'(1);
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sole owner of the check counters.
    initial begin
        exp_t         e;
        bit           in_flight;
        int           accept_cyc;
        logic [W-1:0] held_q;
        logic [W-1:0] held_r;
        logic         held_dbz;
        in_flight  = 1'b0;
        accept_cyc = 0;
        held_q     = '0;
        held_r     = '0;
        held_dbz   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("reset_outputs",
                      {quotient, remainder, div_by_zero, busy, done} === '0,
                      32'({quotient, remainder, div_by_zero, busy, done}), 32'd0);
                exp_q.delete();
                in_flight = 1'b0;
                held_q    = '0;
                held_r    = '0;
                held_dbz  = 1'b0;
            end else begin
                check("busy", busy === in_flight, 32'(busy), 32'(in_flight));
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1'b0, 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn %0h/%0h: q=%0h r=%0h dbz=%0b lat=%0d (want q=%0h r=%0h dbz=%0b lat=%0d)",
                                 e.a, e.b, quotient, remainder, div_by_zero, cyc - accept_cyc,
                                 e.q, e.r, e.dbz, e.lat);
                        check("quotient", quotient === e.q, 32'(quotient), 32'(e.q));
                        check("remainder", remainder === e.r, 32'(remainder), 32'(e.r));
                        check("div_by_zero", div_by_zero === e.dbz, 32'(div_by_zero), 32'(e.dbz));
                        check("latency", (cyc - accept_cyc) == e.lat, 32'(cyc - accept_cyc), 32'(e.lat));
                        held_q   = e.q;
                        held_r   = e.r;
                        held_dbz = e.dbz;
                    end
                    in_flight = 1'b0;
                end else begin
                    check("outputs_stable",
                          {quotient, remainder, div_by_zero} === {held_q, held_r, held_dbz},
                          32'({quotient, remainder, div_by_zero}), 32'({held_q, held_r, held_dbz}));
                    if (in_flight && (cyc - accept_cyc) > 40) begin
                        check("done_timeout", 1'b0, 32'(cyc - accept_cyc), 32'(W + 1));
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        in_flight = 1'b0;
                    end
                end
                if (start && !busy) begin
                    accept_cyc = cyc;
                    in_flight  = 1'b1;
                end
            end
            if (cyc > 30000) begin
                check("watchdog", 1'b0, 32'(cyc), 32'd30000);
                tb_end = 1'b1;
            end
            if (tb_end) begin
                check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        exp_t e;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef DIV_SIGNED_EN
        do_op(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1);  // -7 / 2
        do_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1);  // -8 / -1 wraps
        do_op(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1);  // 7 / -2
        do_op(4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1, 1);  // -7 / 0
        do_op(4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 4);  // 6 / 3, start held
        do_op(4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1);  // -8 / 1
`else
        do_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1);
        do_op(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1);
        do_op(4'd10, 4'd3, 4'd3,  4'd1, 1'b0, 1);
        do_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        do_op(4'd2,  4'd9, 4'd0,  4'd2, 1'b0, 1);
        do_op(4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 1);
        do_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1);
        do_op(4'd14, 4'd8, 4'd1,  4'd6, 1'b0, 1);
`endif

        // Abort 13/3 with reset during cycle 3; no done must follow.
        @(posedge clk);
        #1;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        e.a = 4'd13; e.b = 4'd3; e.q = '0; e.r = '0; e.dbz = 1'b0; e.lat = W + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);

`ifdef DIV_SIGNED_EN
        do_op(4'd5, 4'd2, 4'd2, 4'd1, 1'b0, 1);
`else
        do_op(4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 1);
`endif

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e = model(W'(a), W'(b));
                do_op(W'(a), W'(b), e.q, e.r, e.dbz, 1);
            end
        end

        repeat (3) @(negedge clk);
        tb_end = 1'b1;
    end

endmodule
